fetch_stage: RTL

//   Instruction-fetch stage directly downstream of the PC register. Issues in-order

---
 rtl/fetch_stage.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage that sits directly after the PC register.
//   It issues in-order requests to instruction memory at the current PC and
//   remembers the PC of each request in a small pending queue. Returned words
//   are paired with their PC and buffered in an output FIFO. Decode reads the
//   FIFO over a valid/ready link. The stage also drives the PC register's hold
//   enable, so the PC advances only when a request is granted.
//
//   Handshakes: a transfer happens in a cycle where valid and ready are both 1.
//   While valid is 1 and ready is 0, the payload stays stable. On the memory
//   side, imem_req_o plays the valid role and imem_gnt_i plays the ready role.
//   imem_rvalid_i is a one-cycle strobe that cannot be back-pressured.
//
//   Optional feature: define FETCH_ALIGN_CHECK_EN to turn a misaligned PC into
//   a synthetic NOP entry (id_misalign_o=1). The stage then holds the PC until
//   flush_i. Without the macro, pc_i[1:0] is dropped from the address and
//   id_misalign_o is tied to 0.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   pc_i            current PC from the PC register
//   pc_hold_o       1 = PC register holds; 0 = PC register loads pc+4/redirect
//   imem_req_o      memory request valid
//   imem_addr_o     word-aligned request address
//   imem_gnt_i      request accepted
//   imem_rvalid_i   in-order response strobe
//   imem_rdata_i    response word
//   flush_i         redirect: drop buffered and in-flight fetches
//   id_valid_o      output entry valid
//   id_ready_i      decode accepts the entry
//   id_pc_o         PC of the output entry
//   id_instr_o      instruction of the output entry
//   id_misalign_o   entry came from a misaligned PC
module fetch_stage #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pc_hold_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_misalign_o
);

  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int OCW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int FPW = $clog2(FIFO_DEPTH);
  localparam int QPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  // Output FIFO storage and control
  logic [31:0]    fifo_pc    [FIFO_DEPTH];
  logic [31:0]    fifo_instr [FIFO_DEPTH];
  logic [FPW-1:0] fifo_rd;
  logic [FPW-1:0] fifo_wr;
  logic [FCW-1:0] fifo_count;

  // PCs of granted requests that are still waiting for a response
  logic [31:0]    pend_pc [MAX_OUTSTANDING];
  logic [QPW-1:0] pend_rd;
  logic [QPW-1:0] pend_wr;

  logic [OCW-1:0] outstanding;
  logic [OCW-1:0] discard;

  logic [31:0] occupancy;
  logic        grant;
  logic        rsp;
  logic        rsp_keep;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic [31:0] push_pc;
  logic [31:0] push_instr;

  logic        misaligned;
  logic        mis_hold;
  logic        mis_push;

  // With a single pending slot the pointer never moves; otherwise the
  // power-of-two depth lets the pointer wrap on its own.
  function automatic logic [QPW-1:0] pend_inc(input logic [QPW-1:0] p);
    if (MAX_OUTSTANDING == 1) return '0;
    else return p + 1'b1;
  endfunction

`ifdef FETCH_ALIGN_CHECK_EN
  logic fifo_mis [FIFO_DEPTH];

  assign misaligned = (pc_i[1:0] != 2'b00);
  // The synthetic entry is queued only after every real response has landed.
  // This keeps the FIFO in program order.
  assign mis_push   = rst && !flush_i && misaligned && !mis_hold &&
                      (discard == '0) && (outstanding == '0) &&
                      (32'(fifo_count) < 32'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mis_hold <= 1'b0;
    end else if (flush_i) begin
      mis_hold <= 1'b0;
    end else if (mis_push) begin
      mis_hold <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push && !flush_i) begin
      fifo_mis[fifo_wr] <= mis_push;
    end
  end

  assign id_misalign_o = fifo_empty ? 1'b0 : fifo_mis[fifo_rd];
`else
  assign misaligned    = 1'b0;
  assign mis_hold      = 1'b0;
  assign mis_push      = 1'b0;
  assign id_misalign_o = 1'b0;
`endif

  assign occupancy = 32'(outstanding) + 32'(fifo_count);

  // Credit rule: every in-flight request already owns a FIFO slot, so a
  // response can always be written.
  assign imem_req_o  = rst && !flush_i && !misaligned && !mis_hold &&
                       (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                       (occupancy < 32'(FIFO_DEPTH)) && (discard == '0);
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign grant       = imem_req_o && imem_gnt_i;
  // During a flush no request goes out, so the PC register loads the redirect.
  assign pc_hold_o   = !(grant || (rst && flush_i));

  // A response with nothing outstanding breaks the memory protocol and is ignored.
  assign rsp        = imem_rvalid_i && (outstanding != '0);
  assign rsp_keep   = rsp && !flush_i && (discard == '0);
  assign fifo_push  = rsp_keep || mis_push;
  assign push_pc    = mis_push ? pc_i : pend_pc[pend_rd];
  assign push_instr = mis_push ? 32'h0000_0013 : imem_rdata_i;

  assign fifo_empty = (fifo_count == '0);
  assign id_valid_o = !fifo_empty;
  assign fifo_pop   = id_valid_o && id_ready_i && !flush_i;
  assign id_pc_o    = fifo_empty ? 32'h0 : fifo_pc[fifo_rd];
  assign id_instr_o = fifo_empty ? 32'h0 : fifo_instr[fifo_rd];

  // Storage arrays need no reset: their contents are only visible while the
  // matching count says the entry is live.
  always_ff @(posedge clk) begin
    if (fifo_push && !flush_i) begin
      fifo_pc[fifo_wr]    <= push_pc;
      fifo_instr[fifo_wr] <= push_instr;
    end
    if (grant) begin
      pend_pc[pend_wr] <= pc_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
    end else if (flush_i) begin
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_push) fifo_wr <= fifo_wr + 1'b1;
      if (fifo_pop)  fifo_rd <= fifo_rd + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // The pending queue is not cleared by a flush. Responses to flushed
  // requests still arrive, and they must still pop their PCs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_rd     <= '0;
      pend_wr     <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      if (grant) pend_wr <= pend_inc(pend_wr);
      if (rsp)   pend_rd <= pend_inc(pend_rd);
      case ({grant, rsp})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (flush_i) begin
        discard <= outstanding - OCW'(rsp);
      end else if (rsp && (discard != '0)) begin
        discard <= discard - 1'b1;
      end
    end
  end

endmodule
